uart_msg_reader: RTL and testbench
==================================

// Module: uart_msg_reader
// PURPOSE
//  Reader for the UART receive path. Waits for GOT_FULL_MESSAGE, acknowledges it with MSG_START,
//  then pops MSG_LEN 16-bit words from the RX message FIFO via RD_REQ/FIFO_Q.
//  Re-emits the words as a valid/ready word stream with FIRST/LAST framing, and checks message parity.
//  Sits between the UART RX message assembler and the board command decoder.
// PARAMETERS
//  CNT_W    16  width of saturating MSG_CNT / ERR_CNT counters
// PORTS
//  CLK              in   1      system clock; all logic on rising edge
//  RST              in   1      asynchronous, active-high reset
//  GOT_FULL_MESSAGE in   1      level: a complete message is waiting in the RX FIFO
//  MSG_LEN          in   8      word count of waiting message; valid while GOT_FULL_MESSAGE=1
//  PARITY_OUT       in   1      received parity bit of waiting message; valid with MSG_LEN
//  MSG_START        out  1      1-cycle pulse: message accepted, MSG_LEN/PARITY_OUT latched
//  RD_REQ           out  1      1-cycle-per-word FIFO pop; FIFO_Q valid exactly 1 cycle later
//  FIFO_Q           in   16     FIFO read data
//  M_DATA           out  16     output word
//  M_VALID          out  1      M_DATA valid
//  M_READY          in   1      downstream accepts; transfer = M_VALID & M_READY
//  M_FIRST          out  1      first word of message (qualified by M_VALID)
//  M_LAST           out  1      last word of message (qualified by M_VALID)
//  M_ERR            out  1      parity mismatch; meaningful only on M_LAST beat
//  LEN_ERR          out  1      1-cycle pulse: zero-length message discarded
//  MSG_CNT          out  CNT_W  good messages delivered, saturating
//  ERR_CNT          out  CNT_W  parity errors + zero-length messages, saturating
// BEHAVIOUR
//  Reset values: all outputs 0; counters 0; state IDLE; skid buffer empty.
//  Parity definition: XOR of all 16*MSG_LEN data bits; M_ERR = computed ^ latched PARITY_OUT.
//  FSM:
//   IDLE  : if GOT_FULL_MESSAGE -> pulse MSG_START, latch len_r=MSG_LEN, par_r=PARITY_OUT,
//           clear rd_cnt/out_cnt/parity acc; MSG_LEN==0 -> pulse LEN_ERR, ERR_CNT+1, go GAP;
//           otherwise go FETCH.
//   FETCH : RD_REQ=1 when rd_cnt<len_r and (buffer occupancy + words in flight) < 2.
//           FIFO_Q captured into 2-entry skid buffer on cycle after RD_REQ; parity acc ^= ^FIFO_Q.
//           Buffer head drives M_DATA/M_VALID; pop on transfer; out_cnt+1 per transfer.
//           M_FIRST = (out_cnt==0); M_LAST = (out_cnt==len_r-1).
//           M_ERR on last beat uses acc including last word (all words read before last beat).
//           Last transfer: MSG_CNT+1 if !M_ERR else ERR_CNT+1; go GAP.
//   GAP   : one idle cycle (lets upstream update GOT_FULL_MESSAGE); -> IDLE.
//  Latency: first RD_REQ the cycle after MSG_START; first M_VALID 1 cycle after first RD_REQ.
//  Throughput: 1 word/cycle with M_READY held 1; message-to-message overhead 3 cycles.
//  Backpressure: M_VALID, once high, holds with M_DATA/flags stable until transfer.
//  RD_REQ never exceeds len_r pops per message; never >2 words outstanding+buffered.
//  GOT_FULL_MESSAGE ignored outside IDLE; MSG_LEN/PARITY_OUT changes mid-message ignored.
//  len_r=255 handled (8-bit counters, compare without wrap). Counters saturate at all-ones.
//  Reset mid-message: immediate abort, buffer flushed, outputs 0; RX FIFO not flushed here.
// TESTING
//  1. MSG_LEN=3, words 0x1234,0x00FF,0x8001, PARITY_OUT=1, M_READY=1 -> MSG_START pulse,
//     3 RD_REQ on consecutive cycles, 3 words on consecutive cycles, FIRST on 1st, LAST on 3rd,
//     M_ERR=0, MSG_CNT=1.
//  2. Same words, PARITY_OUT=0 -> identical stream, M_ERR=1 on LAST beat, ERR_CNT=1, MSG_CNT=0.
//  3. MSG_LEN=8, M_READY toggling 1,0,0,1,... -> words 0..7 delivered in order, no loss or
//     duplication, data stable while stalled, never >2 words outstanding+buffered.
//  4. MSG_LEN=0, GOT_FULL_MESSAGE=1 -> MSG_START + LEN_ERR pulses, no RD_REQ, ERR_CNT+1, back in IDLE.
//  5. Back-to-back messages LEN=1 then LEN=255 -> both complete, 256 words, LAST only on word 1 and word 256.
//  6. RST asserted after 2nd word of a LEN=5 message -> all outputs 0 next edge; after release,
//     new message delivered correctly.

Source files
------------

// File: rtl/uart_msg_reader_if.sv
// Handshake bundle between the UART RX message FIFO/assembler, the message
// reader, and the downstream command decoder.
interface uart_msg_reader_if #(parameter int CNT_W = 16);
  logic             got_full_message;
  logic [7:0]       msg_len;
  logic             parity_out;
  logic             msg_start;
  logic             rd_req;
  logic [15:0]      fifo_q;
  logic [15:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_first;
  logic             m_last;
  logic             m_err;
  logic             len_err;
  logic [CNT_W-1:0] msg_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    input  got_full_message, msg_len, parity_out, fifo_q, m_ready,
    output msg_start, rd_req, m_data, m_valid, m_first, m_last, m_err,
           len_err, msg_cnt, err_cnt
  );

  modport slave (
    output got_full_message, msg_len, parity_out, fifo_q, m_ready,
    input  msg_start, rd_req, m_data, m_valid, m_first, m_last, m_err,
           len_err, msg_cnt, err_cnt
  );
endinterface

// File: rtl/uart_msg_reader.sv
// Pops one complete message out of the RX FIFO and re-emits it as a framed
// valid/ready word stream, checking message parity on the last beat.
module uart_msg_reader #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  uart_msg_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [7:0]       len_r, rd_cnt, out_cnt;
  logic             par_r, acc;
  logic             rd_req_r, rd_d;
  logic [1:0]       occ;
  logic [15:0]      buf0, buf1;
  logic             msg_start_r, len_err_r;
  logic [CNT_W-1:0] msg_cnt_r, err_cnt_r;

  logic [15:0] head, buf0_n, buf1_n;
  logic [1:0]  occ_n;
  logic [7:0]  rd_cnt_n;
  logic        m_valid_c, xfer, acc_eff, first_c, last_c, err_c, rd_req_n;

  // A word arriving from the FIFO is presented in the same cycle when the
  // skid buffer is empty; otherwise it queues behind the buffered head.
  always_comb begin
    head      = (occ != 2'd0) ? buf0 : bus.fifo_q;
    m_valid_c = (occ != 2'd0) | rd_d;
    xfer      = m_valid_c & bus.m_ready;
    acc_eff   = acc ^ (rd_d & (^bus.fifo_q));
    first_c   = m_valid_c & (out_cnt == 8'd0);
    last_c    = m_valid_c & (out_cnt == len_r - 8'd1);
    err_c     = last_c & (acc_eff ^ par_r);

    buf0_n = buf0;
    buf1_n = buf1;
    occ_n  = occ;
    case ({xfer, rd_d})
      2'b01: begin
        if (occ == 2'd0) buf0_n = bus.fifo_q;
        else             buf1_n = bus.fifo_q;
        occ_n = occ + 2'd1;
      end
      2'b10: begin
        buf0_n = buf1;
        occ_n  = occ - 2'd1;
      end
      2'b11: begin
        if (occ == 2'd1) begin
          buf0_n = bus.fifo_q;
        end else if (occ == 2'd2) begin
          buf0_n = buf1;
          buf1_n = bus.fifo_q;
        end
      end
      default: ;
    endcase

    // Next-cycle request only if the word it fetches will still have room:
    // buffered words plus the one landing next cycle must stay below two.
    rd_cnt_n = rd_cnt + {7'd0, rd_req_r};
    rd_req_n = (state == FETCH) && !(xfer && last_c) && (rd_cnt_n < len_r) &&
               (({1'b0, occ_n} + {2'b00, rd_req_r}) < 3'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_r       <= 8'd0;
      rd_cnt      <= 8'd0;
      out_cnt     <= 8'd0;
      par_r       <= 1'b0;
      acc         <= 1'b0;
      rd_req_r    <= 1'b0;
      rd_d        <= 1'b0;
      occ         <= 2'd0;
      buf0        <= 16'd0;
      buf1        <= 16'd0;
      msg_start_r <= 1'b0;
      len_err_r   <= 1'b0;
      msg_cnt_r   <= '0;
      err_cnt_r   <= '0;
    end else begin
      msg_start_r <= 1'b0;
      len_err_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.got_full_message) begin
            msg_start_r <= 1'b1;
            len_r       <= bus.msg_len;
            par_r       <= bus.parity_out;
            rd_cnt      <= 8'd0;
            out_cnt     <= 8'd0;
            acc         <= 1'b0;
            rd_req_r    <= 1'b0;
            rd_d        <= 1'b0;
            occ         <= 2'd0;
            if (bus.msg_len == 8'd0) begin
              len_err_r <= 1'b1;
              if (err_cnt_r != '1) err_cnt_r <= err_cnt_r + CNT_ONE;
              state <= GAP;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          rd_req_r <= rd_req_n;
          rd_cnt   <= rd_cnt_n;
          rd_d     <= rd_req_r;
          occ      <= occ_n;
          buf0     <= buf0_n;
          buf1     <= buf1_n;
          acc      <= acc_eff;
          if (xfer) begin
            out_cnt <= out_cnt + 8'd1;
            if (last_c) begin
              state <= GAP;
              if (err_c) begin
                if (err_cnt_r != '1) err_cnt_r <= err_cnt_r + CNT_ONE;
              end else begin
                if (msg_cnt_r != '1) msg_cnt_r <= msg_cnt_r + CNT_ONE;
              end
            end
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data is forced to zero when nothing is presented so stale FIFO output
  // never leaks onto the stream.
  assign bus.m_data    = m_valid_c ? head : 16'd0;
  assign bus.m_valid   = m_valid_c;
  assign bus.m_first   = first_c;
  assign bus.m_last    = last_c;
  assign bus.m_err     = err_c;
  assign bus.rd_req    = rd_req_r;
  assign bus.msg_start = msg_start_r;
  assign bus.len_err   = len_err_r;
  assign bus.msg_cnt   = msg_cnt_r;
  assign bus.err_cnt   = err_cnt_r;
endmodule

// File: tb/tb_uart_msg_reader.sv
// Randomized scoreboard bench: an RX FIFO model feeds the reader, and a
// negedge monitor checks every delivered word against queued expectations.
module tb_uart_msg_reader;
  typedef struct packed {
    logic [15:0] d;
    logic        f;
    logic        l;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_msg_reader_if #(.CNT_W(16)) bus();
  uart_msg_reader #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0, pops = 0, xfers = 0;
  int lenerr_seen = 0, exp_lenerr = 0, m_msg = 0, m_err = 0;
  int start_cyc = 0, rd_cyc = 0, first_cyc = 0, last_cyc = 0;
  bit got_rd = 1'b0;
  int rmode = 0, pat = 0;

  logic [15:0] fifo_m[$];
  logic [15:0] wq[$];
  exp_t        exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // RX FIFO model: data appears the cycle after a pop; garbage otherwise.
  initial begin
    logic pend;
    bus.fifo_q = 16'd0;
    forever begin
      @(negedge clk);
      pend = bus.rd_req & ~rst;
      @(posedge clk);
      #1;
      if (pend && !rst) begin
        if (fifo_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL fifo_underflow actual=pop required=no_pop");
          bus.fifo_q = 16'($urandom);
        end else begin
          bus.fifo_q = fifo_m.pop_front();
        end
      end else begin
        bus.fifo_q = 16'($urandom);
      end
    end
  end

  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'($urandom_range(0, 1));
        default: begin bus.m_ready = (pat == 0); pat = (pat + 1) % 3; end
      endcase
    end
  end

  // Monitor: pops the scoreboard on each transfer, checks hold under stall
  // and the outstanding-word bound.
  initial begin
    logic        stall;
    logic [19:0] pv, cur;
    exp_t        e;
    stall = 1'b0;
    pv = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin stall = 1'b0; continue; end
      if (bus.msg_start) begin start_cyc = cyc; got_rd = 1'b0; end
      if (bus.len_err) lenerr_seen++;
      if (bus.rd_req) begin
        if (!got_rd) begin rd_cyc = cyc; got_rd = 1'b1; end
        pops++;
        chk("outstanding_le2", 32'(pops - xfers <= 2), 32'd1);
      end
      cur = {bus.m_valid, bus.m_data, bus.m_first, bus.m_last, bus.m_err & bus.m_last};
      if (stall) chk("stall_hold", 32'(cur), 32'(pv));
      if (bus.m_valid) begin
        if (bus.m_ready) begin
          xfers++;
          stall = 1'b0;
          if (bus.m_first) first_cyc = cyc;
          if (bus.m_last) last_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word actual=%0h required=none", bus.m_data);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", 32'(bus.m_data), 32'(e.d));
            chk("word_first", 32'(bus.m_first), 32'(e.f));
            chk("word_last", 32'(bus.m_last), 32'(e.l));
            if (e.l) chk("word_err", 32'(bus.m_err), 32'(e.e));
          end
        end else begin
          stall = 1'b1;
          pv = cur;
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic fill_rand(input int len);
    wq.delete();
    for (int i = 0; i < len; i++) wq.push_back(16'($urandom));
  endtask

  // Queue the message in wq: expected beats, FIFO contents, counter model.
  task automatic send_msg(input logic par);
    int   len, n;
    logic p;
    exp_t e;
    len = wq.size();
    p = 1'b0;
    foreach (wq[i]) begin
      p ^= ^wq[i];
      fifo_m.push_back(wq[i]);
      e.d = wq[i];
      e.f = (i == 0);
      e.l = (i == len - 1);
      e.e = (i == len - 1) && (p ^ par);
      exp_q.push_back(e);
    end
    if (len == 0) begin exp_lenerr++; m_err++; end
    else if (p ^ par) m_err++;
    else m_msg++;
    @(posedge clk);
    #1;
    bus.got_full_message = 1'b1;
    bus.msg_len = 8'(len);
    bus.parity_out = par;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.msg_start && n < 2000);
    chk("msg_start_seen", 32'(bus.msg_start), 32'd1);
    chk("len_err_pulse", 32'(bus.len_err), 32'(len == 0));
    @(posedge clk);
    #1;
    bus.got_full_message = 1'b0;
    bus.msg_len = 8'($urandom);
    bus.parity_out = 1'($urandom);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk({nm, "_words_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk({nm, "_fifo_left"}, 32'(fifo_m.size()), 32'd0);
    chk({nm, "_msg_cnt"}, 32'(bus.msg_cnt), 32'(m_msg));
    chk({nm, "_err_cnt"}, 32'(bus.err_cnt), 32'(m_err));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    chk({nm, "_m_data"}, 32'(bus.m_data), 32'd0);
    chk({nm, "_flags"}, 32'({bus.m_first, bus.m_last, bus.m_err}), 32'd0);
    chk({nm, "_rd_req"}, 32'(bus.rd_req), 32'd0);
    chk({nm, "_pulses"}, 32'({bus.msg_start, bus.len_err}), 32'd0);
    chk({nm, "_msg_cnt"}, 32'(bus.msg_cnt), 32'd0);
    chk({nm, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
  endtask

  initial begin
    int base, n;
    bus.got_full_message = 1'b0;
    bus.msg_len = 8'd0;
    bus.parity_out = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Known words, matching parity, full-rate delivery and latency
    rmode = 0;
    wq = '{16'h1234, 16'h00FF, 16'h8001};
    send_msg(1'b1);
    drain("t1");
    chk("t1_rd_latency", 32'(rd_cyc - start_cyc), 32'd1);
    chk("t1_first_latency", 32'(first_cyc - start_cyc), 32'd2);
    chk("t1_last_latency", 32'(last_cyc - start_cyc), 32'd4);

    // Same words, wrong parity
    wq = '{16'h1234, 16'h00FF, 16'h8001};
    send_msg(1'b0);
    drain("t2");

    // Backpressure pattern 1,0,0
    rmode = 2;
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(16'(i));
    send_msg(1'b0);
    drain("t3");

    // Zero-length message
    rmode = 0;
    wq.delete();
    send_msg(1'b0);
    drain("t4");
    chk("t4_len_err_count", 32'(lenerr_seen), 32'(exp_lenerr));

    // Back-to-back LEN=1 then LEN=255
    fill_rand(1);
    send_msg(1'($urandom));
    fill_rand(255);
    send_msg(1'($urandom));
    drain("t5");

    // Random messages under random backpressure, issued back-to-back
    rmode = 1;
    for (int k = 0; k < 20; k++) begin
      fill_rand(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20));
      send_msg(1'($urandom));
    end
    drain("rand");
    chk("rand_len_err_count", 32'(lenerr_seen), 32'(exp_lenerr));

    // Reset after the second word of a LEN=5 message
    rmode = 0;
    base = xfers;
    fill_rand(5);
    send_msg(1'($urandom));
    n = 0;
    while (xfers < base + 2 && n < 200) begin @(negedge clk); n++; end
    chk("t6_two_words", 32'(xfers - base >= 2), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("t6_reset");
    fifo_m.delete();
    exp_q.delete();
    m_msg = 0;
    m_err = 0;
    pops = 0;
    xfers = 0;
    repeat (3) @(negedge clk);
    chk_zero("t6_held");
    rst = 1'b0;
    fill_rand(6);
    send_msg(1'($urandom));
    drain("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
